// File: rtl/perf_event_counters.sv
// Multi-channel event counters plus a free-running cycle counter.
// A halt freezes every count and streams it out over a valid/ready port.
module perf_event_counters #(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 32,
   parameter int SATURATE = 0,
   parameter int IDX_W    = $clog2(NUM_CH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cnt_en,
   input  logic              clr,
   input  logic [NUM_CH-1:0] events,
   input  logic              halt,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [IDX_W-1:0]  dump_idx,
   output logic [CNT_W-1:0]  dump_data,
   output logic              dump_last,
   output logic              done,
   output logic [NUM_CH:0]   ovf
);

   localparam int NC = NUM_CH + 1;

   typedef enum logic [1:0] {RUN, DUMP, DONE} state_t;

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   cnt_q [NC];
   logic [CNT_W-1:0]   cnt_d [NC];
   logic [NUM_CH:0]    ovf_d;
   logic [NUM_CH:0]    ev_all;
   logic               xfer;
   logic [IDX_W-1:0]   idx_nxt;

   // the top slot is the cycle counter, which counts every enabled cycle
   assign ev_all  = {1'b1, events};
   assign xfer    = dump_valid & dump_ready;
   assign idx_nxt = dump_idx + 1'b1;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:     if (halt) state_d = DUMP;
         DUMP:    if (xfer && dump_last) state_d = DONE;
         DONE:    state_d = DONE;
         default: state_d = RUN;
      endcase
      if (clr) state_d = RUN;
   end

   always_comb begin
      ovf_d = ovf;
      for (int i = 0; i < NC; i++) begin
         cnt_d[i] = cnt_q[i];
         if (state_q == RUN && cnt_en && ev_all[i]) begin
            if (&cnt_q[i]) begin
               ovf_d[i] = 1'b1;
               if (SATURATE == 0) cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         for (int i = 0; i < NC; i++) cnt_q[i] <= '0;
         ovf        <= '0;
         dump_valid <= 1'b0;
         dump_idx   <= '0;
         dump_data  <= '0;
         dump_last  <= 1'b0;
         done       <= 1'b0;
      end else if (clr) begin
         state_q <= RUN;
         for (int i = 0; i < NC; i++) cnt_q[i] <= '0;
         ovf        <= '0;
         dump_valid <= 1'b0;
         dump_idx   <= '0;
         dump_data  <= '0;
         dump_last  <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_q <= state_d;
         for (int i = 0; i < NC; i++) cnt_q[i] <= cnt_d[i];
         ovf <= ovf_d;
         unique case (state_q)
            RUN: begin
               // first beat carries the count including the halt cycle
               if (halt) begin
                  dump_valid <= 1'b1;
                  dump_idx   <= '0;
                  dump_data  <= cnt_d[0];
                  dump_last  <= 1'b0;
               end
            end
            DUMP: begin
               if (xfer) begin
                  if (dump_last) begin
                     dump_valid <= 1'b0;
                     dump_last  <= 1'b0;
                     done       <= 1'b1;
                  end else begin
                     dump_idx  <= idx_nxt;
                     dump_data <= cnt_q[idx_nxt];
                     dump_last <= (idx_nxt == IDX_W'(NUM_CH));
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_perf_event_counters.sv
// Bench for perf_event_counters: wrap and saturate instances run in lockstep,
// dumped beats are checked against a queue of expected beats.
module tb_perf_event_counters;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cnt_en = 1'b0;
   logic       clr = 1'b0;
   logic       halt = 1'b0;
   logic       dump_ready = 1'b0;
   logic [3:0] events = '0;

   logic       d_valid, d_last, d_done;
   logic       s_valid, s_last, s_done;
   logic [2:0] d_idx, s_idx;
   logic [7:0] d_data, s_data;
   logic [4:0] d_ovf, s_ovf;

   always #5 clk = ~clk;

   perf_event_counters #(
      .NUM_CH(4), .CNT_W(8), .SATURATE(0)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .cnt_en(cnt_en), .clr(clr),
      .events(events), .halt(halt),
      .dump_valid(d_valid), .dump_ready(dump_ready),
      .dump_idx(d_idx), .dump_data(d_data), .dump_last(d_last),
      .done(d_done), .ovf(d_ovf)
   );

   perf_event_counters #(
      .NUM_CH(4), .CNT_W(8), .SATURATE(1)
   ) u_sat (
      .clk(clk), .rst_n(rst_n), .cnt_en(cnt_en), .clr(clr),
      .events(events), .halt(halt),
      .dump_valid(s_valid), .dump_ready(dump_ready),
      .dump_idx(s_idx), .dump_data(s_data), .dump_last(s_last),
      .done(s_done), .ovf(s_ovf)
   );

   typedef struct packed {
      logic [2:0] idx;
      logic [7:0] data;
      logic       last;
   } beat_t;

   typedef struct packed {
      logic [15:0]       n;
      logic [3:0][15:0]  k;
      logic [15:0]       off;
      logic              bp;
      logic [4:0][7:0]   e;
      logic [4:0][7:0]   se;
      logic [4:0]        ov;
      logic [4:0]        sov;
   } vec_t;

   beat_t q[$];
   beat_t qs[$];
   vec_t  tbl[5];
   vec_t  tv;
   int    pass = 0;
   int    total = 0;

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got === exp) pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   function automatic vec_t mkv(input int n, input int k0, input int k1,
                                input int k2, input int k3, input int off,
                                input bit bp, input logic [39:0] e,
                                input logic [39:0] se, input logic [4:0] ov,
                                input logic [4:0] sov);
      vec_t v;
      v.n   = 16'(n);
      v.k   = {16'(k3), 16'(k2), 16'(k1), 16'(k0)};
      v.off = 16'(off);
      v.bp  = bp;
      v.e   = e;
      v.se  = se;
      v.ov  = ov;
      v.sov = sov;
      return v;
   endfunction

   // cycle c (1..n): events[i] while c<=k[i], cnt_en when c>off, halt at c==n
   task automatic run_vec(input vec_t v, input bit do_clr);
      if (do_clr) begin
         @(posedge clk); #1;
         clr = 1'b1; halt = 1'b1; events = 4'hF; cnt_en = 1'b1;
         @(posedge clk); #1;
         clr = 1'b0; halt = 1'b0; events = '0; cnt_en = 1'b0;
         chk("clr_valid", 64'(d_valid), 64'(0));
         chk("clr_done", 64'(d_done), 64'(0));
         chk("clr_ovf", 64'(d_ovf), 64'(0));
         chk("clr_sat_ovf", 64'(s_ovf), 64'(0));
      end else begin
         @(posedge clk); #1;
      end
      for (int c = 1; c <= int'(v.n); c++) begin
         cnt_en = (c > int'(v.off));
         for (int i = 0; i < 4; i++) events[i] = (c <= int'(v.k[i]));
         halt = (c == int'(v.n));
         @(posedge clk); #1;
      end
      halt = 1'b0; events = '0; cnt_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         q.push_back('{idx: 3'(i), data: v.e[i], last: (i == 4)});
         qs.push_back('{idx: 3'(i), data: v.se[i], last: (i == 4)});
      end
   endtask

   task automatic collect(input bit bp);
      bit         fin;
      logic [4:0] pat;
      fin = 1'b0;
      pat = 5'b10100;
      for (int k = 0; k < 60 && !fin; k++) begin
         dump_ready = bp ? pat[k % 5] : 1'b1;
         @(negedge clk);
         if (d_done) begin
            fin = 1'b1;
            if (!bp) chk("done_latency", 64'(k), 64'(5));
            chk("sat_done", 64'(s_done), 64'(1));
         end else if (!d_valid || q.size() == 0 || qs.size() == 0) begin
            chk("beat_valid", 64'(d_valid && q.size() != 0), 64'(1));
         end else begin
            chk("beat_idx", 64'(d_idx), 64'(q[0].idx));
            chk("beat_data", 64'(d_data), 64'(q[0].data));
            chk("beat_last", 64'(d_last), 64'(q[0].last));
            chk("sat_valid", 64'(s_valid), 64'(1));
            chk("sat_idx", 64'(s_idx), 64'(qs[0].idx));
            chk("sat_data", 64'(s_data), 64'(qs[0].data));
            chk("sat_last", 64'(s_last), 64'(qs[0].last));
            if (dump_ready) begin
               void'(q.pop_front());
               void'(qs.pop_front());
            end
         end
         @(posedge clk); #1;
      end
      chk("dump_finished", 64'(fin), 64'(1));
      chk("beats_left", 64'(q.size()), 64'(0));
      q.delete();
      qs.delete();
   endtask

   initial begin
      tbl[0] = mkv(20, 10, 0, 3, 0, 0, 1'b0,
                   {8'd20, 8'd0, 8'd3, 8'd0, 8'd10},
                   {8'd20, 8'd0, 8'd3, 8'd0, 8'd10}, 5'b0, 5'b0);
      tbl[1] = mkv(20, 10, 0, 3, 0, 0, 1'b1,
                   {8'd20, 8'd0, 8'd3, 8'd0, 8'd10},
                   {8'd20, 8'd0, 8'd3, 8'd0, 8'd10}, 5'b0, 5'b0);
      tbl[2] = mkv(12, 0, 0, 0, 12, 5, 1'b0,
                   {8'd7, 8'd7, 8'd0, 8'd0, 8'd0},
                   {8'd7, 8'd7, 8'd0, 8'd0, 8'd0}, 5'b0, 5'b0);
      tbl[3] = mkv(261, 0, 260, 0, 0, 0, 1'b0,
                   {8'd5, 8'd0, 8'd0, 8'd4, 8'd0},
                   {8'd255, 8'd0, 8'd0, 8'd255, 8'd0},
                   5'b10010, 5'b10010);
      tbl[4] = mkv(9, 1, 2, 5, 9, 2, 1'b1,
                   {8'd7, 8'd7, 8'd3, 8'd0, 8'd0},
                   {8'd7, 8'd7, 8'd3, 8'd0, 8'd0}, 5'b0, 5'b0);

      @(posedge clk); #1;
      chk("rst_valid", 64'(d_valid), 64'(0));
      chk("rst_idx", 64'(d_idx), 64'(0));
      chk("rst_data", 64'(d_data), 64'(0));
      chk("rst_last", 64'(d_last), 64'(0));
      chk("rst_done", 64'(d_done), 64'(0));
      chk("rst_ovf", 64'(d_ovf), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      for (int t = 0; t < 5; t++) begin
         run_vec(tbl[t], 1'b1);
         collect(tbl[t].bp);
         chk("ovf", 64'(d_ovf), 64'(tbl[t].ov));
         chk("sat_ovf", 64'(s_ovf), 64'(tbl[t].sov));
      end

      // halt while DONE must not restart the dump
      halt = 1'b1; events = 4'hF; cnt_en = 1'b1;
      @(posedge clk); #1;
      halt = 1'b0; events = '0; cnt_en = 1'b0;
      @(negedge clk);
      chk("done_halt_valid", 64'(d_valid), 64'(0));
      chk("done_halt_done", 64'(d_done), 64'(1));

      // clr during beat 2 aborts the dump, counting resumes from zero
      tv = mkv(5, 5, 5, 5, 5, 0, 1'b0, '0, '0, 5'b0, 5'b0);
      run_vec(tv, 1'b1);
      dump_ready = 1'b1;
      @(negedge clk);
      chk("abort_idx0", 64'(d_idx), 64'(0));
      @(posedge clk); #1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk("abort_idx2", 64'(d_idx), 64'(2));
      clr = 1'b1;
      dump_ready = 1'b0;
      @(posedge clk); #1;
      clr = 1'b0;
      @(negedge clk);
      chk("abort_valid", 64'(d_valid), 64'(0));
      chk("abort_done", 64'(d_done), 64'(0));
      q.delete();
      qs.delete();
      tv = mkv(3, 3, 0, 0, 0, 0, 1'b0,
               {8'd3, 8'd0, 8'd0, 8'd0, 8'd3},
               {8'd3, 8'd0, 8'd0, 8'd0, 8'd3}, 5'b0, 5'b0);
      run_vec(tv, 1'b0);
      collect(1'b0);

      // asynchronous reset during beat 1
      tv = mkv(6, 6, 0, 0, 0, 0, 1'b0, '0, '0, 5'b0, 5'b0);
      run_vec(tv, 1'b1);
      dump_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_rst_idx1", 64'(d_idx), 64'(1));
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(d_valid), 64'(0));
      chk("mid_rst_idx", 64'(d_idx), 64'(0));
      chk("mid_rst_data", 64'(d_data), 64'(0));
      chk("mid_rst_last", 64'(d_last), 64'(0));
      chk("mid_rst_done", 64'(d_done), 64'(0));
      q.delete();
      qs.delete();
      @(negedge clk);
      rst_n = 1'b1;
      tv = mkv(4, 0, 0, 4, 0, 0, 1'b0,
               {8'd4, 8'd0, 8'd4, 8'd0, 8'd0},
               {8'd4, 8'd0, 8'd4, 8'd0, 8'd0}, 5'b0, 5'b0);
      run_vec(tv, 1'b0);
      collect(1'b0);

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule

// File: doc/perf_event_counters.md
Name: perf_event_counters

Overview:
- Synthesizable multi-channel event/performance counter unit. Replaces ad-hoc bench-side counting of retired instructions and I/D cache requests and hits.
- Instantiated beside the pipeline in proc_hier. Each channel counts one 1-bit event strobe, and a free-running cycle counter runs alongside them.
- On a halt strobe, all counters freeze and the unit streams every count out over a valid/ready dump port, for the bench or a debug sink.

Parameters:
- NUM_CH, 4, number of event channels (1..16).
- CNT_W, 32, width of each counter and of the cycle counter (8..64).
- SATURATE, 0: 0 = counters wrap modulo 2^CNT_W; 1 = counters stick at all-ones.
- IDX_W, $clog2(NUM_CH+1), width of dump_idx (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cnt_en  in  1  global count enable; the cycle counter also obeys it.
- clr  in  1  synchronous clear of all counters and overflow flags.
- events  in  NUM_CH  per-channel event strobes; bit i increments channel i.
- halt  in  1  freeze-and-dump request (single-cycle strobe or level).
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  sink accepts the beat.
- dump_idx  out  IDX_W  channel index of the beat; NUM_CH = cycle counter.
- dump_data  out  CNT_W  counter value of the beat.
- dump_last  out  1  high on the final beat (cycle counter).
- done  out  1  dump complete, unit frozen.
- ovf  out  NUM_CH+1  sticky overflow flags; bit NUM_CH = cycle counter.

Behaviour:
- State machine has three states: RUN, DUMP, DONE.
- Reset (rst_n=0, asynchronous):
  - state=RUN; all counters=0; ovf=0; dump_valid=0; dump_idx=0; dump_data=0; dump_last=0; done=0.
  - Reset asserted mid-dump aborts the dump immediately.
- RUN, counting:
  - Each cycle with cnt_en=1: cycle counter +1, and channel i +1 if events[i]=1.
  - With cnt_en=0, all counters hold.
- Increment rules:
  - Wrap mode: all-ones +1 -> 0, and the ovf bit sets.
  - Saturate mode: all-ones +1 holds all-ones, and the ovf bit sets.
  - ovf bits are sticky until clr or reset.
- RUN, halt=1 (and clr=0):
  - Events and cnt_en in the halt cycle are still counted, so the halt cycle itself is included.
  - Next state is DUMP with dump_idx=0.
  - Counters are frozen from the following cycle onward.
- DUMP:
  - dump_valid=1; dump_data = counter[dump_idx] (registered output, frozen value); dump_last = (dump_idx==NUM_CH).
  - Beat transfers on dump_valid & dump_ready.
  - On transfer with dump_last=0: dump_idx+1.
  - On transfer with dump_last=1: state -> DONE, dump_valid=0.
  - While dump_ready=0, dump_idx, dump_data and dump_last hold stable (AXI-style; valid never drops before transfer).
  - Exactly NUM_CH+1 beats, in index order 0..NUM_CH.
- DONE: done=1, dump_valid=0, counters frozen; halt ignored.
- halt in DUMP or DONE: ignored (no restart of the dump).
- clr behaviour:
  - From any state: counters=0, ovf=0, state -> RUN, dump_valid=0, done=0, dump_idx=0. No increment occurs in the clr cycle.
  - clr has priority over halt and over events in the same cycle.
- Latency:
  - Halt at cycle T gives first beat valid at T+1.
  - With dump_ready held high, done rises at T+NUM_CH+2.
- Counter arithmetic is unsigned CNT_W-bit. No combinational path from events to dump_data.

Test Plan:
- Basic counts: NUM_CH=4, cnt_en=1; events[0] high 10 cycles, events[2] high 3 cycles, halt at cycle 20 (counting from 1 after reset release), dump_ready=1. Expect beats (0,10),(1,0),(2,3),(3,0),(4,20); dump_last only on idx 4; done at halt+6.
- Backpressure: same run, dump_ready toggling 0,0,1,0,1 repeatedly. Expect every beat held stable while ready=0, no beat dropped or duplicated, still 5 beats total.
- Wrap vs saturate: CNT_W=8, events[1] constantly high for 260 cycles.
  - SATURATE=0: channel 1 = 4, ovf[1]=1.
  - SATURATE=1: channel 1 = 255, ovf[1]=1.
- clr priority: clr and halt asserted together with events=4'hF. Expect state RUN, all counters 0, no dump started. clr during beat 2 of a dump aborts it: dump_valid=0 next cycle, counting resumes.
- Reset mid-dump: drop rst_n during beat 1. Expect all outputs 0 immediately, asynchronously; after release, counting restarts from 0.
- Enable gating: cnt_en=0 for 5 of 12 cycles with events[3]=1 throughout. Expect channel 3 = 7 and cycle counter = 7.
